// File: rtl/str_decim.sv
// Purpose : stream decimator; keeps one sample per RATIO accepted inputs (pick) or their mean (STR_DECIM_AVG_EN).
// Latency : one cycle from the emitting input handshake to m_axis_tvalid when the output queue is empty.
// Backpr. : 2-deep output queue; s_axis_tready drops only in the emit slot while the queue is full (registered only).

// Small generic synchronous FIFO. DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         full,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          wr_en;
    logic          rd_en;

    assign full   = (cnt_q == (AW+1)'(DEPTH));
    assign rd_vld = (cnt_q != '0);
    assign rd_dat = mem_q[rd_ptr_q];
    assign wr_en  = wr_vld & ~full;
    assign rd_en  = rd_vld & rd_rdy;

    // Next-state for storage, pointers and occupancy; simultaneous push/pop keeps the count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO state registers; storage clears on reset so the output bus reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// Purpose : decimate an AXI-stream sample flow by RATIO; optional averaging under macro STR_DECIM_AVG_EN.
// Latency : result visible the cycle after the emitting input handshake (queue empty).
// Backpr. : input stalls only in the emit slot with the 2-entry queue full; no comb path from m_axis_tready.
module str_decim #(
    parameter int DW    = 24,
    parameter int RATIO = 4,
    parameter int PHASE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] s_axis_tdata,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready
);
    localparam int CW = $clog2(RATIO);

`ifdef STR_DECIM_AVG_EN
    localparam bit AVG_MODE = 1'b1;
`else
    localparam bit AVG_MODE = 1'b0;
`endif

    // Averaging emits on the last sample of the frame; pick mode emits on the chosen phase.
    localparam int            EMIT_IDX  = AVG_MODE ? (RATIO - 1) : PHASE;
    localparam logic [CW-1:0] EMIT_SLOT = CW'(EMIT_IDX);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          emit_slot;
    logic          ish;
    logic          push_vld;
    logic [DW-1:0] push_dat;
    logic          fifo_full;

    assign emit_slot     = (cnt_q == EMIT_SLOT);
    // Only registered state feeds tready: the slot counter and the queue-full flag.
    assign s_axis_tready = ~emit_slot | ~fifo_full;
    assign ish           = s_axis_tvalid & s_axis_tready;
    assign push_vld      = ish & emit_slot;

    // Frame phase advances on each accepted sample and wraps at RATIO.
    always_comb begin
        cnt_d = cnt_q;
        if (ish) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Phase counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef STR_DECIM_AVG_EN
    localparam int AW = DW + CW;

    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [AW-1:0] sum;

    // Running frame sum including the current sample; the extra CW bits rule out overflow.
    assign sum = acc_q + {{CW{s_axis_tdata[DW-1]}}, s_axis_tdata};
    // The top DW bits of sum are exactly (sum >>> CW) truncated to DW, i.e. floor of the mean.
    assign push_dat = sum[CW +: DW];

    // Accumulate inside the frame, restart from zero once the mean has been emitted.
    always_comb begin
        acc_d = acc_q;
        if (ish) begin
            acc_d = emit_slot ? '0 : sum;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    assign push_dat = s_axis_tdata;
`endif

    sync_fifo #(
        .W     (DW),
        .DEPTH (2)
    ) u_out_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (push_vld),
        .wr_dat (push_dat),
        .full   (fifo_full),
        .rd_vld (m_axis_tvalid),
        .rd_rdy (m_axis_tready),
        .rd_dat (m_axis_tdata)
    );
endmodule

// File: tb/tb_str_decim.sv
// Purpose : randomized and directed check of str_decim against a frame-level reference model.
// Latency : model expects a result at the output the cycle after its emitting input handshake.
// Backpr. : model tracks the 2-entry output queue to predict s_axis_tready each cycle.
module tb_str_decim;
    localparam int DW    = 12;
    localparam int RATIO = 4;
    localparam int PHASE = 1;
`ifdef STR_DECIM_AVG_EN
    localparam bit AVG  = 1'b1;
    localparam int EMIT = RATIO - 1;
`else
    localparam bit AVG  = 1'b0;
    localparam int EMIT = PHASE;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_dat;
    logic          s_vld;
    logic          s_rdy;
    logic [DW-1:0] m_dat;
    logic          m_vld;
    logic          m_rdy;

    always #5 clk = ~clk;

    str_decim #(
        .DW    (DW),
        .RATIO (RATIO),
        .PHASE (PHASE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_dat),
        .s_axis_tvalid (s_vld),
        .s_axis_tready (s_rdy),
        .m_axis_tdata  (m_dat),
        .m_axis_tvalid (m_vld),
        .m_axis_tready (m_rdy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: accepted-sample count, running frame sum, queue of pending results.
    int            n_in = 0;
    longint        fsum = 0;
    logic [DW-1:0] expq[$];
    logic [DW-1:0] obs[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit exp_rdy();
        return !(((n_in % RATIO) == EMIT) && (expq.size() == 2));
    endfunction

    // One clock: check outputs, drive inputs, advance the model. Called and returns at negedge.
    task automatic step(input bit sv, input bit mr, input logic [DW-1:0] d);
        bit     rdy;
        bit     ish;
        longint q;
        rdy = exp_rdy();
        chk("tvalid", 32'(m_vld), 32'(expq.size() != 0));
        chk("tready", 32'(s_rdy), 32'(rdy));
        if (expq.size() != 0) chk("tdata", 32'(m_dat), 32'(expq[0]));
        s_vld = sv;
        s_dat = d;
        m_rdy = mr;
        #1;
        chk("tready_comb", 32'(s_rdy), 32'(rdy));
        ish = sv && rdy;
        if (expq.size() != 0 && mr) begin
            obs.push_back(m_dat);
            void'(expq.pop_front());
        end
        if (ish) begin
            if (AVG) fsum += longint'($signed(d));
            if ((n_in % RATIO) == EMIT) begin
                if (AVG) begin
                    q = fsum / RATIO;
                    if (fsum < 0 && (fsum % RATIO) != 0) q = q - 1;
                    expq.push_back(DW'(q));
                    fsum = 0;
                end else begin
                    expq.push_back(d);
                end
            end
            n_in++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n_hi;
        bit reached;
        rst_n = 1'b0;
        s_vld = 1'b0;
        s_dat = '0;
        m_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_tvalid", 32'(m_vld), 32'd0);
        chk("rst_tready", 32'(s_rdy), 32'd1);
        chk("rst_tdata",  32'(m_dat), 32'd0);
        rst_n = 1'b1;

        // Directed frame sequence with downstream always ready.
        obs.delete();
`ifdef STR_DECIM_AVG_EN
        begin
            int vin [8] = '{4, 8, 12, 16, -1, -1, -1, -2};
            for (int i = 0; i < 8; i++) step(1'b1, 1'b1, DW'(vin[i]));
            step(1'b0, 1'b1, '0);
            step(1'b0, 1'b1, '0);
            chk("avg_cnt", 32'(obs.size()), 32'd2);
            chk("avg_out0", 32'(obs[0]), 32'(DW'(10)));
            chk("avg_out1", 32'(obs[1]), 32'(DW'(-2)));
        end
`else
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, DW'(i));
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        chk("pick_cnt", 32'(obs.size()), 32'd4);
        for (int k = 0; k < 4; k++) chk("pick_out", 32'(obs[k]), 32'(4 * k + 1));
`endif

        // Backpressure: downstream stalled, continuous input from frame start.
        obs.delete();
        n_hi = 0;
        for (int i = 0; i < 14; i++) begin
            if (s_rdy) n_hi++;
            step(1'b1, 1'b0, DW'(200 + i));
        end
        chk("bp_accepted", 32'(n_hi), 32'(EMIT + 2 * RATIO));
        chk("bp_full_vld", 32'(m_vld), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0);
        chk("bp_drain_cnt", 32'(obs.size()), 32'd2);
        chk("bp_drain0", 32'(obs[0]), 32'd201);
        chk("bp_drain1", 32'(obs[1]), 32'd205);

        // Mid-frame reset with one queued result.
        reached = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (expq.size() == 1 && (n_in % RATIO) == 2) begin
                reached = 1'b1;
                break;
            end
            step(1'b1, 1'b0, DW'(300 + i));
        end
        chk("rst_setup", 32'(reached), 32'd1);
        rst_n = 1'b0;
        s_vld = 1'b0;
        #1;
        chk("arst_tvalid", 32'(m_vld), 32'd0);
        chk("arst_tready", 32'(s_rdy), 32'd1);
        chk("arst_tdata",  32'(m_dat), 32'd0);
        expq.delete();
        n_in = 0;
        fsum = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        obs.delete();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, DW'(100 + i));
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        chk("post_rst_cnt", 32'(obs.size()), 32'd1);
        chk("post_rst_out", 32'(obs[0]), 32'd101);

        // Random valid/ready at 50% until 10000 inputs accepted (bounded).
        begin
            int base;
            base = n_in;
            for (int c = 0; c < 40000 && (n_in - base) < 10000; c++) begin
                step(1'($urandom % 2), 1'($urandom % 2), DW'($urandom));
            end
            chk("rand_inputs", 32'(n_in - base >= 10000), 32'd1);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0);
        chk("final_empty", 32'(expq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/str_decim.md
STR_DECIM -- requirements
Module: str_decim

Interface
REQ-001 Parameter: DW, 24, sample width, signed two's complement (Q1.(DW-1)), same format as the upstream FIR output.
REQ-002 Parameter: RATIO, 4, decimation factor; power of two, 2..256.
REQ-003 Parameter: PHASE, 0, index (0..RATIO-1) of the input sample kept per frame in pick mode.
REQ-004 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: s_axis_tdata  input  DW  input sample from the FIR stage.
REQ-007 Port: s_axis_tvalid  input  1  input sample valid.
REQ-008 Port: s_axis_tready  output  1  block accepts an input sample.
REQ-009 Port: m_axis_tdata  output  DW  decimated sample.
REQ-010 Port: m_axis_tvalid  output  1  output sample valid.
REQ-011 Port: m_axis_tready  input  1  downstream accepts the output sample.

Function
REQ-012 Input handshake (ish) = s_axis_tvalid & s_axis_tready; output handshake (osh) = m_axis_tvalid & m_axis_tready.
REQ-013 Phase counter cnt, width log2(RATIO), increments by 1 on every ish and wraps RATIO-1 -> 0; it holds when no ish occurs.
REQ-014 Emit slot: cnt==PHASE in pick mode; cnt==RATIO-1 in average mode (REQ-024).
REQ-015 An ish in the emit slot pushes one result into a 2-entry output FIFO; an ish outside the emit slot pushes nothing.
REQ-016 s_axis_tready = (cnt != emit slot) | (FIFO count < 2); it depends only on registered state and has no combinational path from m_axis_tready.
REQ-017 m_axis_tvalid = (FIFO count != 0); m_axis_tdata = FIFO head; head and valid hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-018 Latency: a pushed result is visible on m_axis_tdata/m_axis_tvalid in the cycle after its ish, if the FIFO was empty.
REQ-019 Push and pop in the same cycle leave the FIFO count unchanged and preserve order; a push while full is impossible by REQ-016.
REQ-020 Throughput: with m_axis_tready held at 1, s_axis_tready never deasserts and one output is produced per RATIO accepted inputs.
REQ-021 Pick mode: the pushed value is s_axis_tdata unchanged.

Reset
REQ-022 While rst_n=0: cnt=0, accumulator=0, FIFO count=0, FIFO storage=0, m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=1.
REQ-023 A reset asserted mid-frame or with the FIFO non-empty discards the partial frame and all queued results; the first ish after release is frame sample 0.

Configuration
REQ-024 Macro STR_DECIM_AVG_EN: when defined, the block runs in average mode; when undefined, it runs in pick mode and contains no accumulator logic.
REQ-025 Average mode: the accumulator is signed, DW+log2(RATIO) bits wide, and has no overflow; on a non-emit ish, acc <= acc + s_axis_tdata.
REQ-026 Average mode, emit ish: the pushed value is (acc + s_axis_tdata) >>> log2(RATIO), an arithmetic shift that truncates toward negative infinity, taking the low DW bits; acc <= 0 in the same cycle.
REQ-027 PHASE is ignored in average mode.

Verification
REQ-028 Pick mode, DW=12, RATIO=4, PHASE=1, m_axis_tready=1, inputs 0,1,2,...,15 on consecutive cycles -> outputs 1,5,9,13, each one cycle after its input.
REQ-029 Average mode, RATIO=4, inputs 4,8,12,16 then -1,-1,-1,-2 -> outputs 10 then -2 (-5>>>2 = -2).
REQ-030 Backpressure: m_axis_tready=0 with continuous valid input, RATIO=2, pick mode -> FIFO fills after 4 inputs; s_axis_tready drops only at the next emit slot; output data is held stable; on release, the outputs emerge in order with no loss or duplication.
REQ-031 Simultaneous push/pop with FIFO count=1 -> count stays 1 and output order is preserved.
REQ-032 Assert rst_n=0 for one cycle after 2 of 4 frame samples, with 1 queued output -> m_axis_tvalid=0 immediately (asynchronous); after release, the next frame starts at sample 0.
REQ-033 Random tvalid/tready at 50% each over 10000 inputs, compared against a reference model -> zero mismatches, and s_axis_tready never depends combinationally on m_axis_tready.
